// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state encoding and the adder slice width.
package serial_add_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_adder4.sv
// adder4: combinational 4-bit ripple-carry slice of full-adder cells.
// Ports: x,y operands; ci carry in; s sum; co carry out.
module adder4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: WIDTH-bit add/sub using one 4-bit slice per clock.
// Ports: start_* operand handshake, res_* result handshake, busy.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE_W-1:0] x_sl, y_sl, s_sl;
  logic               co_sl;

  // Constant-index mux keeps the slice select free of
  // variable part-selects.
  always_comb begin
    x_sl = '0;
    y_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        x_sl = a_q[i*SLICE_W +: SLICE_W];
        y_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  adder4 u_slice (
    .x  (x_sl),
    .y  (y_sl),
    .ci (carry_q),
    .s  (s_sl),
    .co (co_sl)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : c_in;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i))
            sum_d[i*SLICE_W +: SLICE_W] = s_sl;
        end
        carry_d = co_sl;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = co_sl;
          // b_q already holds the inverted operand for subtract.
          ovf_d   = (a_q[MSB] == b_q[MSB]) &&
                    (s_sl[SLICE_W-1] != a_q[MSB]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q == RUN) || (state_q == DONE);
  assign sum         = sum_q;
  assign c_out       = cout_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=16.
// Ports: none; drives and checks the DUT from one initial block.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a, b;
  logic        c_in, sub;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] sum;
  logic        c_out, ovf, busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(16)) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .c_out       (c_out),
    .ovf         (ovf),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept, scramble inputs, wait for result with a bound.
  task automatic start_op(input logic [15:0] ta, tb,
                          input logic tc, ts,
                          output int lat);
    bit seen;
    chk("op_start_ready", 32'(start_ready), 32'd1);
    a = ta; b = tb; c_in = tc; sub = ts;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; c_in = 1'b1; sub = 1'b0;
    chk("accept_sum_clear", 32'(sum), 32'd0);
    chk("accept_busy", 32'(busy), 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      step();
      if (res_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [15:0] ta, tb,
                       input logic tc, ts,
                       input logic [15:0] es,
                       input logic ec, eo);
    int lat;
    res_ready = 1'b1;
    start_op(ta, tb, tc, ts, lat);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(c_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    step();
    chk({tag, "_idle"}, 32'(start_ready), 32'd1);
    chk({tag, "_rv_low"}, 32'(res_valid), 32'd0);
    chk({tag, "_held"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int lat;
    resetn = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    step();
    step();
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_rv", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sr", 32'(start_ready), 32'd1);
    resetn = 1'b1;
    step();

    do_op("add", 16'h1234, 16'h4321, 1'b0, 1'b0,
          16'h5555, 1'b0, 1'b0);
    do_op("chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0,
          16'h0000, 1'b1, 1'b0);
    do_op("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
          16'h8000, 1'b0, 1'b1);
    do_op("cin", 16'h0010, 16'h0020, 1'b1, 1'b0,
          16'h0031, 1'b0, 1'b0);
    do_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1,
          16'hFFFE, 1'b0, 1'b0);
    do_op("sub2", 16'h8000, 16'h0001, 1'b1, 1'b1,
          16'h7FFF, 1'b1, 1'b1);

    // Backpressure with start_valid pulsing in DONE.
    res_ready = 1'b0;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      start_valid = i[0];
      a = 16'h0100 + 16'(i);
      b = 16'h0F00;
      sub = i[1];
      step();
      chk("bp_rv", 32'(res_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h3333);
      chk("bp_sr", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b1;
    a = 16'h0001; b = 16'h0002; c_in = 1'b0; sub = 1'b0;
    res_ready = 1'b1;
    step();
    chk("bp_idle_sr", 32'(start_ready), 32'd1);
    chk("bp_idle_rv", 32'(res_valid), 32'd0);
    res_ready = 1'b0;
    step();
    chk("bp_accept_busy", 32'(busy), 32'd1);
    chk("bp_accept_sr", 32'(start_ready), 32'd0);
    start_valid = 1'b0;
    a = 16'hAAAA; b = 16'h5555;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("bp_pend_rv", 32'(res_valid), 32'd1);
    chk("bp_pend_sum", 32'(sum), 32'h0003);
    step();

    // Reset asserted at E2 of an add.
    res_ready = 1'b1;
    chk("mr_sr", 32'(start_ready), 32'd1);
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mr_sr_after", 32'(start_ready), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_sum", 32'(sum), 32'd0);
    chk("mr_cout", 32'(c_out), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mr_rv", 32'(res_valid), 32'd0);
    end

    do_op("post_rst", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0,
          16'h0000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
